sram_ctrl: RTL and testbench
============================

# sram_ctrl

Memory-side adapter between the single-cycle core's load/store port and the board's 256K×16 asynchronous SRAM pins. It turns one 32-bit word request into two sequenced 16-bit SRAM accesses, low half first, with per-byte write masking. It returns read data and a one-cycle acknowledge to the core. All SRAM pin controls come from registered state, so no combinational path runs from core inputs to the pins.

## Interface
Parameters:
- none; geometry is fixed at 18-bit halfword address and 16-bit data.

Ports:
- i_clk  in  1  core clock (CLOCK_50/4).
- i_rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- i_addr  in  19  byte address; bits [1:0] are ignored (word aligned).
- i_wdata  in  32  write data, little-endian.
- i_bmask  in  4  byte enables; bit n enables byte n.
- i_rden  in  1  read request.
- i_wren  in  1  write request.
- o_rdata  out  32  read data.
- o_ack  out  1  one-cycle completion pulse.
- o_busy  out  1  high while a transaction is in flight.
- o_sram_addr  out  18  halfword address.
- io_sram_dq  inout  16  SRAM data bus.
- o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_ub_n, o_sram_lb_n  out  1 each  active-low SRAM strobes.

## Operation
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, ACK.
- Request acceptance:
  - Requests are sampled only in IDLE.
  - On acceptance, i_addr[18:2], i_wdata and i_bmask are captured into registers. Later input changes are ignored.
- Transitions:
  - IDLE: i_wren goes to WR_LO and wins over i_rden. i_rden alone goes to RD_LO.
  - RD_LO goes to RD_HI, which goes to ACK.
  - WR_LO goes to WR_HI, which goes to ACK.
  - ACK goes to IDLE.
- Address: LO states drive {word,1'b0}; HI states drive {word,1'b1}.
- Lanes: the LO half carries bytes 0/1 and the HI half carries bytes 2/3. lb_n selects dq[7:0] and ub_n selects dq[15:8].
- Reads:
  - ce_n=0, oe_n=0, ub_n=lb_n=0, dq tri-stated.
  - dq is captured into o_rdata[15:0] at the end of RD_LO and into o_rdata[31:16] at the end of RD_HI.
  - o_rdata holds until the next read completes.
- Writes:
  - ce_n=0, oe_n=1, dq driven with the relevant wdata half.
  - ub_n/lb_n are the inverted mask bits for that half.
  - we_n=0 only if that half has at least one mask bit set; otherwise the half is a no-op cycle with we_n=1.
- Bus direction: dq is driven only in WR_LO and WR_HI. It is 'z in every other state and during reset.
- o_busy=1 in every state except IDLE. o_ack=1 only in ACK.
- Reset mid-transaction:
  - Returns to IDLE on the next edge and drops all strobes.
  - An in-progress write half is truncated. The other half is never written.

## Timing
- Reset values:
  - o_ack=0, o_busy=0, o_rdata=0, o_sram_addr=0.
  - we_n=oe_n=ce_n=ub_n=lb_n=1; dq='z.
- Latency: request sampled at edge 0, o_ack high during cycle 3 (edges 3–4). o_rdata is valid in the ACK cycle.
- Throughput: the next request can be sampled in the cycle after ACK, giving at most one word per 4 cycles.
- Write strobes: address, dq and byte enables are stable for the whole cycle in which we_n=0. we_n falls and rises on clock edges together with the state change.
- Requests during a non-IDLE state are dropped. The core must hold its request until o_ack.

## Configuration
- SRAM_CTRL_WAIT_EN defined:
  - Each of the four access states lasts 2 cycles, counted by a 1-bit wait counter.
  - Strobes are asserted in both cycles; read capture happens only at the end of the second cycle.
  - o_ack arrives in cycle 5.
- Undefined: one cycle per half; o_ack in cycle 3.

## Test plan
- Full-word write: write 0xDEADBEEF, mask 4'b1111, i_addr 0x00010. The SRAM model must hold 0xBEEF at halfword 0x00008 and 0xDEAD at 0x00009. o_ack must pulse in cycle 3 (cycle 5 with SRAM_CTRL_WAIT_EN).
- Read-back: read i_addr 0x00010 → o_rdata=0xDEADBEEF when o_ack is high. dq must be 'z throughout the read.
- Byte write: write 0x00AA0000, mask 4'b0100, to the same address.
  - WR_LO: we_n stays 1.
  - WR_HI: we_n=0, lb_n=0, ub_n=1.
  - Read-back → 0xDEAABEEF.
- Simultaneous requests: i_rden=i_wren=1 in IDLE → a write is performed. A second request raised while o_busy=1 is ignored (no extra o_ack).
- Reset mid-write: assert i_rst_n=0 in WR_LO of a write of 0x12345678 to 0x00020.
  - The next cycle shows all strobes high, o_busy=0, o_ack=0.
  - Halfword 0x00011 is unchanged.

Source files
------------

// File: rtl/sram_ctrl.sv
// 32-bit core port to 256Kx16 async SRAM adapter: two halfword accesses per word, low half first.
// Optional SRAM_CTRL_WAIT_EN stretches each access state to two cycles.
module sram_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [18:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_bmask,
    input  logic        i_rden,
    input  logic        i_wren,
    output logic [31:0] o_rdata,
    output logic        o_ack,
    output logic        o_busy,
    output logic [17:0] o_sram_addr,
    inout  logic [15:0] io_sram_dq,
    output logic        o_sram_we_n,
    output logic        o_sram_oe_n,
    output logic        o_sram_ce_n,
    output logic        o_sram_ub_n,
    output logic        o_sram_lb_n
);

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, ACK} state_t;

    state_t      state;
    logic [16:0] word;
    logic [15:0] wdata_hi;
    logic [1:0]  bmask_hi;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic        step;
    logic        addr_unused;

    assign addr_unused = ^i_addr[1:0];
    assign io_sram_dq  = dq_oe ? dq_out : 16'hzzzz;

`ifdef SRAM_CTRL_WAIT_EN
    logic wait_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || state == IDLE || state == ACK)
            wait_cnt <= 1'b0;
        else
            wait_cnt <= ~wait_cnt;
    end

    assign step = wait_cnt;
`else
    assign step = 1'b1;
`endif

    // Pin controls are loaded on the edge that enters a state, so they are
    // valid for that state's whole cycle. The low write half goes straight
    // from the inputs; only the high half needs to be held.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_ack       <= 1'b0;
            o_busy      <= 1'b0;
            o_rdata     <= '0;
            o_sram_addr <= '0;
            o_sram_we_n <= 1'b1;
            o_sram_oe_n <= 1'b1;
            o_sram_ce_n <= 1'b1;
            o_sram_ub_n <= 1'b1;
            o_sram_lb_n <= 1'b1;
            dq_oe       <= 1'b0;
            dq_out      <= '0;
            word        <= '0;
            wdata_hi    <= '0;
            bmask_hi    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_wren) begin
                        state       <= WR_LO;
                        word        <= i_addr[18:2];
                        wdata_hi    <= i_wdata[31:16];
                        bmask_hi    <= i_bmask[3:2];
                        o_busy      <= 1'b1;
                        o_sram_addr <= {i_addr[18:2], 1'b0};
                        o_sram_ce_n <= 1'b0;
                        o_sram_oe_n <= 1'b1;
                        o_sram_lb_n <= ~i_bmask[0];
                        o_sram_ub_n <= ~i_bmask[1];
                        o_sram_we_n <= ~|i_bmask[1:0];
                        dq_oe       <= 1'b1;
                        dq_out      <= i_wdata[15:0];
                    end else if (i_rden) begin
                        state       <= RD_LO;
                        word        <= i_addr[18:2];
                        o_busy      <= 1'b1;
                        o_sram_addr <= {i_addr[18:2], 1'b0};
                        o_sram_ce_n <= 1'b0;
                        o_sram_oe_n <= 1'b0;
                        o_sram_lb_n <= 1'b0;
                        o_sram_ub_n <= 1'b0;
                    end
                end
                RD_LO: begin
                    if (step) begin
                        state         <= RD_HI;
                        o_rdata[15:0] <= io_sram_dq;
                        o_sram_addr   <= {word, 1'b1};
                    end
                end
                RD_HI: begin
                    if (step) begin
                        state          <= ACK;
                        o_rdata[31:16] <= io_sram_dq;
                        o_ack          <= 1'b1;
                        o_sram_ce_n    <= 1'b1;
                        o_sram_oe_n    <= 1'b1;
                        o_sram_lb_n    <= 1'b1;
                        o_sram_ub_n    <= 1'b1;
                    end
                end
                WR_LO: begin
                    if (step) begin
                        state       <= WR_HI;
                        o_sram_addr <= {word, 1'b1};
                        o_sram_lb_n <= ~bmask_hi[0];
                        o_sram_ub_n <= ~bmask_hi[1];
                        o_sram_we_n <= ~|bmask_hi;
                        dq_out      <= wdata_hi;
                    end
                end
                WR_HI: begin
                    if (step) begin
                        state       <= ACK;
                        o_ack       <= 1'b1;
                        o_sram_we_n <= 1'b1;
                        o_sram_ce_n <= 1'b1;
                        o_sram_lb_n <= 1'b1;
                        o_sram_ub_n <= 1'b1;
                        dq_oe       <= 1'b0;
                    end
                end
                ACK: begin
                    state  <= IDLE;
                    o_ack  <= 1'b0;
                    o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural 256Kx16 async SRAM on the pins.
// Honours SRAM_CTRL_WAIT_EN for the expected acknowledge cycle.
module tb_sram_ctrl;

`ifdef SRAM_CTRL_WAIT_EN
    localparam int ACK_CYC = 5;
`else
    localparam int ACK_CYC = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [18:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  bmask = '0;
    logic        rden = 1'b0;
    logic        wren = 1'b0;
    logic [31:0] rdata;
    logic        ack, busy;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    sram_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_wdata(wdata), .i_bmask(bmask),
        .i_rden(rden), .i_wren(wren), .o_rdata(rdata), .o_ack(ack), .o_busy(busy),
        .o_sram_addr(sram_addr), .io_sram_dq(sram_dq), .o_sram_we_n(we_n),
        .o_sram_oe_n(oe_n), .o_sram_ce_n(ce_n), .o_sram_ub_n(ub_n), .o_sram_lb_n(lb_n)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:262143];

    assign sram_dq = (!ce_n && !oe_n) ? mem[sram_addr] : 16'hzzzz;

    always @(negedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
            if (!ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
        end
    end

    int total = 0;
    int bad = 0;

    logic [1:0]  obs_we, obs_oe, obs_lb, obs_ub;
    logic [15:0] obs_dq [2];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Holds the request until ack, recording pin state per half along the way.
    task automatic xfer(input logic wr, input logic rd, input logic [18:0] a,
                        input logic [31:0] wd, input logic [3:0] m,
                        output int ack_at, output logic [31:0] rd_at_ack);
        int h;
        wren = wr; rden = rd; addr = a; wdata = wd; bmask = m;
        ack_at = -1; rd_at_ack = '0;
        obs_we = 2'bxx; obs_oe = 2'bxx; obs_lb = 2'bxx; obs_ub = 2'bxx;
        for (int c = 1; c <= 12 && ack_at < 0; c++) begin
            tick;
            if (ack) begin
                ack_at = c;
                rd_at_ack = rdata;
            end else if (busy) begin
                h = int'(sram_addr[0]);
                obs_we[h] = we_n; obs_oe[h] = oe_n;
                obs_lb[h] = lb_n; obs_ub[h] = ub_n;
                obs_dq[h] = sram_dq;
            end
        end
        wren = 1'b0; rden = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick; tick;
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%0h exp=0", ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%08h exp=00000000", rdata); end
        total++; if (sram_addr !== 18'h0) begin bad++; $display("FAIL reset_addr got=%05h exp=00000", sram_addr); end
        total++; if ({we_n, oe_n, ce_n, ub_n, lb_n} !== 5'b11111) begin
            bad++; $display("FAIL reset_strobes got=%05b exp=11111", {we_n, oe_n, ce_n, ub_n, lb_n});
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_full_write;
        int          at;
        logic [31:0] r;
        xfer(1'b1, 1'b0, 19'h00010, 32'hDEADBEEF, 4'b1111, at, r);
        total++; if (at != ACK_CYC) begin bad++; $display("FAIL wr_ack_cycle got=%0d exp=%0d", at, ACK_CYC); end
        total++; if (mem[18'h8] !== 16'hBEEF) begin bad++; $display("FAIL wr_mem_lo got=%04h exp=beef", mem[18'h8]); end
        total++; if (mem[18'h9] !== 16'hDEAD) begin bad++; $display("FAIL wr_mem_hi got=%04h exp=dead", mem[18'h9]); end
        total++; if (obs_dq[0] !== 16'hBEEF) begin bad++; $display("FAIL wr_dq_lo got=%04h exp=beef", obs_dq[0]); end
        total++; if (obs_dq[1] !== 16'hDEAD) begin bad++; $display("FAIL wr_dq_hi got=%04h exp=dead", obs_dq[1]); end
        total++; if (obs_we !== 2'b00) begin bad++; $display("FAIL wr_we got=%02b exp=00", obs_we); end
        total++; if (obs_oe !== 2'b11) begin bad++; $display("FAIL wr_oe got=%02b exp=11", obs_oe); end
        total++; if (busy !== 1'b0 || ack !== 1'b0) begin
            bad++; $display("FAIL wr_idle_after got=%0b%0b exp=00", busy, ack);
        end
    endtask

    task automatic test_read;
        int          at;
        logic [31:0] r;
        xfer(1'b0, 1'b1, 19'h00010, 32'h0, 4'b0000, at, r);
        total++; if (at != ACK_CYC) begin bad++; $display("FAIL rd_ack_cycle got=%0d exp=%0d", at, ACK_CYC); end
        total++; if (r !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%08h exp=deadbeef", r); end
        total++; if (obs_oe !== 2'b00) begin bad++; $display("FAIL rd_oe got=%02b exp=00", obs_oe); end
        total++; if (obs_we !== 2'b11) begin bad++; $display("FAIL rd_we got=%02b exp=11", obs_we); end
        total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_hold got=%08h exp=deadbeef", rdata); end
    endtask

    task automatic test_byte_write;
        int          at;
        logic [31:0] r;
        xfer(1'b1, 1'b0, 19'h00010, 32'h00AA0000, 4'b0100, at, r);
        total++; if (obs_we !== 2'b01) begin bad++; $display("FAIL bw_we got=%02b exp=01", obs_we); end
        total++; if (obs_lb[1] !== 1'b0 || obs_ub[1] !== 1'b1) begin
            bad++; $display("FAIL bw_lanes_hi got=ub%0b_lb%0b exp=ub1_lb0", obs_ub[1], obs_lb[1]);
        end
        xfer(1'b0, 1'b1, 19'h00010, 32'h0, 4'b0000, at, r);
        total++; if (r !== 32'hDEAABEEF) begin bad++; $display("FAIL bw_readback got=%08h exp=deaabeef", r); end
    endtask

    task automatic test_simultaneous;
        int acks = 0;
        wren = 1'b1; rden = 1'b1; addr = 19'h00040; wdata = 32'h11223344; bmask = 4'b1111;
        tick;
        if (ack) acks++;
        wren = 1'b0; rden = 1'b0;
        tick;
        if (ack) acks++;
        rden = 1'b1; addr = 19'h00010;
        tick;
        if (ack) acks++;
        rden = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (ack) acks++;
        end
        total++; if (acks != 1) begin bad++; $display("FAIL sim_ack_count got=%0d exp=1", acks); end
        total++; if (mem[18'h20] !== 16'h3344) begin bad++; $display("FAIL sim_mem_lo got=%04h exp=3344", mem[18'h20]); end
        total++; if (mem[18'h21] !== 16'h1122) begin bad++; $display("FAIL sim_mem_hi got=%04h exp=1122", mem[18'h21]); end
    endtask

    task automatic test_reset_mid_write;
        int          at;
        logic [31:0] r;
        xfer(1'b1, 1'b0, 19'h00020, 32'hCAFE0000, 4'b1100, at, r);
        total++; if (mem[18'h11] !== 16'hCAFE) begin bad++; $display("FAIL rst_preset got=%04h exp=cafe", mem[18'h11]); end
        wren = 1'b1; addr = 19'h00020; wdata = 32'h12345678; bmask = 4'b1111;
        tick;
        total++; if (we_n !== 1'b0 || sram_addr !== 18'h10) begin
            bad++; $display("FAIL rst_in_wr_lo got=we%0b_a%05h exp=we0_a00010", we_n, sram_addr);
        end
        rst_n = 1'b0; wren = 1'b0;
        tick;
        total++; if ({we_n, oe_n, ce_n, ub_n, lb_n} !== 5'b11111) begin
            bad++; $display("FAIL rst_strobes got=%05b exp=11111", {we_n, oe_n, ce_n, ub_n, lb_n});
        end
        total++; if (busy !== 1'b0 || ack !== 1'b0) begin
            bad++; $display("FAIL rst_busy_ack got=%0b%0b exp=00", busy, ack);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) tick;
        total++; if (mem[18'h11] !== 16'hCAFE) begin bad++; $display("FAIL rst_hi_untouched got=%04h exp=cafe", mem[18'h11]); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_stays_idle got=%0b exp=0", busy); end
    endtask

    task automatic test_back_to_back;
        int first = -1;
        int second = -1;
        rden = 1'b1; addr = 19'h00010;
        for (int c = 1; c <= 30 && second < 0; c++) begin
            tick;
            if (ack) begin
                if (first < 0) first = c;
                else second = c;
            end
        end
        rden = 1'b0;
        tick; tick;
        total++; if (first != ACK_CYC) begin bad++; $display("FAIL b2b_first got=%0d exp=%0d", first, ACK_CYC); end
        total++; if (second != 2 * ACK_CYC + 1) begin
            bad++; $display("FAIL b2b_second got=%0d exp=%0d", second, 2 * ACK_CYC + 1);
        end
        total++; if (rdata !== 32'hDEAABEEF) begin bad++; $display("FAIL b2b_data got=%08h exp=deaabeef", rdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset;
        test_full_write;
        test_read;
        test_byte_write;
        test_simultaneous;
        test_back_to_back;
        test_reset_mid_write;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
